// File: rtl/root_result_collector.sv
// Collects leaf/overall latency result messages for one test case and presents a summary record.
// Optional statistics (test count, latency sum, max latency) are enabled by defining RESULT_STATS_EN.
module root_result_collector #(
  parameter int         NUM_LEAVES    = 1,
  parameter logic [7:0] HEADER_RESULT = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] sum_data,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [15:0] drop_count,
  output logic [31:0] stat_count,
  output logic [47:0] stat_sum,
  output logic [15:0] stat_max
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [6:0] LP_NUM_LEAVES = 7'(NUM_LEAVES);
  localparam logic [6:0] LP_CNT_MAX    = 7'd127;

  state_t      r_state;
  logic [6:0]  r_leaf_cnt;
  logic [15:0] r_leaf_max;
  logic [23:0] r_test_idx;
  logic [15:0] r_drop_cnt;
  logic [63:0] r_sum_data;
  logic        r_sum_valid;

  logic        w_in_xfer;
  logic        w_sum_xfer;
  logic        w_is_result;
  logic        w_is_overall;
  logic [15:0] w_lat;
  logic [6:0]  w_leaf_cnt_inc;
  logic [15:0] w_leaf_max_upd;
  logic        w_unused;

  // in_ready is forced low for the whole reset window, including the cycle reset is first seen
  assign in_ready       = ~reset & (r_state != REPORT);
  assign w_in_xfer      = in_valid & in_ready;
  assign w_sum_xfer     = r_sum_valid & sum_ready;
  assign w_is_result    = (in_data[63:56] == HEADER_RESULT);
  assign w_is_overall   = in_data[55];
  assign w_lat          = in_data[15:0];
  assign w_leaf_cnt_inc = (r_leaf_cnt == LP_CNT_MAX) ? LP_CNT_MAX : r_leaf_cnt + 7'd1;
  assign w_leaf_max_upd = (w_lat > r_leaf_max) ? w_lat : r_leaf_max;
  assign w_unused       = ^in_data[54:16];

  assign sum_data   = r_sum_data;
  assign sum_valid  = r_sum_valid;
  assign drop_count = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_leaf_cnt  <= 7'd0;
      r_leaf_max  <= 16'd0;
      r_test_idx  <= 24'd0;
      r_sum_data  <= 64'd0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_xfer && w_is_result) begin
            if (w_is_overall) begin
              r_sum_data  <= {w_lat, 16'd0, r_test_idx, 7'd0, 1'b1};
              r_sum_valid <= 1'b1;
              r_state     <= REPORT;
            end else begin
              r_leaf_cnt <= 7'd1;
              r_leaf_max <= w_lat;
              r_state    <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_in_xfer && w_is_result) begin
            if (w_is_overall) begin
              r_sum_data  <= {w_lat, r_leaf_max, r_test_idx, r_leaf_cnt,
                              (r_leaf_cnt != LP_NUM_LEAVES)};
              r_sum_valid <= 1'b1;
              r_state     <= REPORT;
            end else begin
              r_leaf_cnt <= w_leaf_cnt_inc;
              r_leaf_max <= w_leaf_max_upd;
            end
          end
        end
        REPORT: begin
          if (w_sum_xfer) begin
            r_sum_valid <= 1'b0;
            r_leaf_cnt  <= 7'd0;
            r_leaf_max  <= 16'd0;
            r_test_idx  <= r_test_idx + 24'd1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_sum_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 16'd0;
    end else if (w_in_xfer && !w_is_result && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

`ifdef RESULT_STATS_EN
  logic [31:0] r_stat_count;
  logic [47:0] r_stat_sum;
  logic [15:0] r_stat_max;

  // the summary register still holds the reported overall latency during the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_count <= 32'd0;
      r_stat_sum   <= 48'd0;
      r_stat_max   <= 16'd0;
    end else if (w_sum_xfer) begin
      r_stat_count <= r_stat_count + 32'd1;
      r_stat_sum   <= r_stat_sum + {32'd0, r_sum_data[63:48]};
      if (r_sum_data[63:48] > r_stat_max)
        r_stat_max <= r_sum_data[63:48];
    end
  end

  assign stat_count = r_stat_count;
  assign stat_sum   = r_stat_sum;
  assign stat_max   = r_stat_max;
`else
  assign stat_count = 32'd0;
  assign stat_sum   = 48'd0;
  assign stat_max   = 16'd0;
`endif

endmodule

// File: tb/tb_root_result_collector.sv
// Self-checking bench for root_result_collector: directed vector table, corner sequences and
// randomized messages checked against a queue-based reference model.
module tb_root_result_collector;

  localparam int         NL  = 2;
  localparam logic [7:0] HDR = 8'h03;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] sum_data;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [15:0] drop_count;
  logic [31:0] stat_count;
  logic [47:0] stat_sum;
  logic [15:0] stat_max;

  root_result_collector #(.NUM_LEAVES(NL), .HEADER_RESULT(HDR)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_data(sum_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .drop_count(drop_count),
    .stat_count(stat_count), .stat_sum(stat_sum), .stat_max(stat_max)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [15:0] m_leaves[$];
  logic [23:0] m_idx;
  logic [15:0] m_drop;
  logic [31:0] m_cnt;
  logic [47:0] m_sum;
  logic [15:0] m_max;

  logic        pend_en = 1'b0;
  logic [63:0] pend_data = 64'd0;

  typedef struct {
    logic [7:0]  hdr;
    logic        kind;
    logic [15:0] lat;
    logic [63:0] exp_data;
    logic [15:0] exp_drop;
  } vec_t;
  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_leaves.delete();
    m_idx  = 24'd0;
    m_drop = 16'd0;
    m_cnt  = 32'd0;
    m_sum  = 48'd0;
    m_max  = 16'd0;
  endtask

  task automatic check_stats_model();
`ifdef RESULT_STATS_EN
    check("stat_count", 64'(stat_count), 64'(m_cnt));
    check("stat_sum", 64'(stat_sum), 64'(m_sum));
    check("stat_max", 64'(stat_max), 64'(m_max));
`else
    check("stat_count_zero", 64'(stat_count), 64'd0);
    check("stat_sum_zero", 64'(stat_sum), 64'd0);
    check("stat_max_zero", 64'(stat_max), 64'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_sum_valid", 64'(sum_valid), 64'd0);
    check("post_rst_sum_data", sum_data, 64'd0);
    check("post_rst_drop", 64'(drop_count), 64'd0);
    check_stats_model();
  endtask

  // Presents one message, waits for acceptance and, for an overall result, checks the summary
  // and completes the handshake after 'hold' cycles of sum_ready low.
  task automatic send(input logic [7:0] hdr, input logic kind, input logic [15:0] lat,
                      input int hold, output logic [63:0] got);
    logic [63:0] exp;
    int n;
    int unsigned cnt;
    logic [15:0] mx;
    got = 64'd0;
    in_data = {hdr, kind, 39'd0, lat};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (hdr != HDR) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end else if (!kind) begin
      m_leaves.push_back(lat);
    end else begin
      cnt = (m_leaves.size() > 127) ? 127 : m_leaves.size();
      mx = 16'd0;
      foreach (m_leaves[i]) if (m_leaves[i] > mx) mx = m_leaves[i];
      exp = {lat, mx, m_idx, cnt[6:0], (cnt != NL)};
      got = sum_data;
      check("sum_valid_latency", 64'(sum_valid), 64'd1);
      check("sum_data", sum_data, exp);
      check("report_in_ready", 64'(in_ready), 64'd0);
      if (pend_en) begin
        in_valid = 1'b1;
        in_data = pend_data;
      end
      for (int c = 0; c < hold; c++) begin
        tick();
        check("hold_data", sum_data, exp);
        check("hold_valid", 64'(sum_valid), 64'd1);
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      check("sum_valid_clear", 64'(sum_valid), 64'd0);
      check("in_ready_after", 64'(in_ready), 64'd1);
      m_cnt = m_cnt + 32'd1;
      m_sum = m_sum + {32'd0, lat};
      if (lat > m_max) m_max = lat;
      m_idx = m_idx + 24'd1;
      m_leaves.delete();
    end
    check("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  initial begin
    logic [63:0] got;
    logic [7:0]  h;
    logic        k;

    vecs[0]  = '{8'h03, 1'b0, 16'h0010, 64'd0, 16'd0};
    vecs[1]  = '{8'h03, 1'b0, 16'h0025, 64'd0, 16'd0};
    vecs[2]  = '{8'h03, 1'b1, 16'h0030, {16'h0030, 16'h0025, 24'd0, 7'd2, 1'b0}, 16'd0};
    vecs[3]  = '{8'h03, 1'b0, 16'h0005, 64'd0, 16'd0};
    vecs[4]  = '{8'h03, 1'b1, 16'h0007, {16'h0007, 16'h0005, 24'd1, 7'd1, 1'b1}, 16'd0};
    vecs[5]  = '{8'h01, 1'b0, 16'h1234, 64'd0, 16'd1};
    vecs[6]  = '{8'h03, 1'b0, 16'h0011, 64'd0, 16'd1};
    vecs[7]  = '{8'h7F, 1'b1, 16'h0999, 64'd0, 16'd2};
    vecs[8]  = '{8'h03, 1'b0, 16'h0022, 64'd0, 16'd2};
    vecs[9]  = '{8'h03, 1'b1, 16'h0033, {16'h0033, 16'h0022, 24'd2, 7'd2, 1'b0}, 16'd2};
    vecs[10] = '{8'h03, 1'b1, 16'h0044, {16'h0044, 16'h0000, 24'd3, 7'd0, 1'b1}, 16'd2};

    model_reset();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].hdr, vecs[i].kind, vecs[i].lat, 0, got);
      if (vecs[i].kind && vecs[i].hdr == HDR)
        check($sformatf("vec%0d_sum", i), got, vecs[i].exp_data);
      check($sformatf("vec%0d_drop", i), 64'(drop_count), 64'(vecs[i].exp_drop));
    end

    // backpressure: a leaf waits upstream while the summary is held for 10 cycles
    pend_data = {HDR, 1'b0, 39'd0, 16'h0050};
    pend_en = 1'b1;
    send(HDR, 1'b1, 16'h0060, 10, got);
    pend_en = 1'b0;
    check("bp_sum", got, {16'h0060, 16'h0000, 24'd4, 7'd0, 1'b1});
    send(HDR, 1'b0, 16'h0050, 0, got);
    send(HDR, 1'b1, 16'h0061, 0, got);
    check("bp_leaf_kept", got, {16'h0061, 16'h0050, 24'd5, 7'd1, 1'b1});

    // reset in COLLECT abandons the pending test
    send(HDR, 1'b0, 16'h0070, 0, got);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("no_summary_after_rst", 64'(sum_valid), 64'd0);
    end
    send(HDR, 1'b0, 16'h0001, 0, got);
    send(HDR, 1'b0, 16'h0002, 0, got);
    send(HDR, 1'b1, 16'h0003, 0, got);
    check("rst_idx0_sum", got, {16'h0003, 16'h0002, 24'd0, 7'd2, 1'b0});

    // statistics over three tests
    do_reset();
    send(HDR, 1'b0, 16'h0001, 0, got);
    send(HDR, 1'b1, 16'h0010, 0, got);
    send(HDR, 1'b1, 16'h0040, 1, got);
    send(HDR, 1'b0, 16'h0009, 0, got);
    send(HDR, 1'b0, 16'h0004, 0, got);
    send(HDR, 1'b1, 16'h0020, 2, got);
    check("three_test_sum", got, {16'h0020, 16'h0009, 24'd2, 7'd2, 1'b0});
`ifdef RESULT_STATS_EN
    check("stat3_count", 64'(stat_count), 64'd3);
    check("stat3_sum", 64'(stat_sum), 64'h70);
    check("stat3_max", 64'(stat_max), 64'h40);
`else
    check("stat3_count_zero", 64'(stat_count), 64'd0);
    check("stat3_sum_zero", 64'(stat_sum), 64'd0);
    check("stat3_max_zero", 64'(stat_max), 64'd0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        h = 8'($urandom_range(0, 255));
        if (h == HDR) h = 8'h04;
      end else begin
        h = HDR;
      end
      k = ($urandom_range(0, 2) == 0);
      send(h, k, 16'($urandom), int'($urandom_range(0, 3)), got);
    end
    check_stats_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
